// File: rtl/regfile_burst_ctrl.sv
// Burst initiator for the 32x32 register file: one command becomes a run of
// consecutive register writes (from a data stream) or reads (onto a data stream).
module regfile_burst_ctrl #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          CmdValid,
  output logic          CmdReady,
  input  logic          CmdWrite,
  input  logic [AW-1:0] CmdBase,
  input  logic [AW-1:0] CmdLen,
  input  logic          WdValid,
  output logic          WdReady,
  input  logic [DW-1:0] Wdata,
  output logic          RdValid,
  input  logic          RdReady,
  output logic [DW-1:0] Rdata,
  output logic          RdLast,
  output logic          Busy,
  output logic          Done,
  output logic [AW-1:0] RfArd,
  input  logic [DW-1:0] RfDout,
  output logic [AW-1:0] RfAwr,
  output logic [DW-1:0] RfDin,
  output logic          RfWrEn,
  output logic [1:0]    DbgState
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] ptr;
  logic [AW-1:0] remain;

  // Handshakes: a beat transfers on the edge where valid & ready are both high;
  // a producer holding valid keeps its payload stable until that edge.
  assign CmdReady = (state == IDLE);
  assign Busy     = (state != IDLE);
  assign WdReady  = (state == WRITE);
  assign RfWrEn   = (state == WRITE) && WdValid;
  assign RfAwr    = ptr;
  assign RfDin    = Wdata;
  assign RfArd    = ptr;
  assign DbgState = state;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      ptr     <= '0;
      remain  <= '0;
      RdValid <= 1'b0;
      Rdata   <= '0;
      RdLast  <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (CmdValid) begin
            ptr    <= CmdBase;
            remain <= CmdLen;
            state  <= CmdWrite ? WRITE : READ;
          end
        end
        WRITE: begin
          if (WdValid) begin
            ptr    <= ptr + 1'b1;
            remain <= remain - 1'b1;
            if (remain == '0) begin
              state <= IDLE;
              Done  <= 1'b1;
            end
          end
        end
        READ: begin
          // Single output register: refill whenever it is empty or being drained.
          if (!RdValid || RdReady) begin
            Rdata   <= RfDout;
            RdValid <= 1'b1;
            RdLast  <= (remain == '0);
            ptr     <= ptr + 1'b1;
            remain  <= remain - 1'b1;
            if (remain == '0) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (RdValid && RdReady && RdLast) begin
            RdValid <= 1'b0;
            RdLast  <= 1'b0;
            state   <= IDLE;
            Done    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_burst_ctrl.sv
// Directed bench for regfile_burst_ctrl: per-cycle vector table plus hand-written
// reset, back-pressure and full-sweep sequences against a behavioural register file.
module tb_regfile_burst_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        CmdValid = 1'b0;
  logic        CmdReady;
  logic        CmdWrite = 1'b0;
  logic [4:0]  CmdBase = '0;
  logic [4:0]  CmdLen = '0;
  logic        WdValid = 1'b0;
  logic        WdReady;
  logic [31:0] Wdata = '0;
  logic        RdValid;
  logic        RdReady = 1'b0;
  logic [31:0] Rdata;
  logic        RdLast;
  logic        Busy;
  logic        Done;
  logic [4:0]  RfArd;
  logic [31:0] RfDout;
  logic [4:0]  RfAwr;
  logic [31:0] RfDin;
  logic        RfWrEn;
  logic [1:0]  DbgState;

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 Clk = ~Clk;

  regfile_burst_ctrl #(.AW(5), .DW(32)) dut (
    .Clk(Clk), .Rst(Rst),
    .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdWrite(CmdWrite),
    .CmdBase(CmdBase), .CmdLen(CmdLen),
    .WdValid(WdValid), .WdReady(WdReady), .Wdata(Wdata),
    .RdValid(RdValid), .RdReady(RdReady), .Rdata(Rdata), .RdLast(RdLast),
    .Busy(Busy), .Done(Done),
    .RfArd(RfArd), .RfDout(RfDout), .RfAwr(RfAwr), .RfDin(RfDin), .RfWrEn(RfWrEn),
    .DbgState(DbgState)
  );

  // behavioural register file: combinational read, write on rising edge
  logic [31:0] rf [32];
  int          wrCount [32];
  logic        preWe = 1'b0;
  logic [4:0]  preAddr = '0;
  logic [31:0] preData = '0;
  logic        wrClr = 1'b0;

  assign RfDout = rf[RfArd];

  always @(posedge Clk) begin
    if (RfWrEn) begin
      rf[RfAwr] <= RfDin;
      wrCount[RfAwr] <= wrCount[RfAwr] + 1;
    end else if (preWe) begin
      rf[preAddr] <= preData;
    end
    if (wrClr) begin
      for (int k = 0; k < 32; k++) wrCount[k] <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic        cv;
    logic        cw;
    logic [4:0]  base;
    logic [4:0]  len;
    logic        wv;
    logic [31:0] wd;
    logic        rr;
    logic        eBusy;
    logic        eDone;
    logic        eWdReady;
    logic        eWrEn;
    logic [4:0]  ePtr;
    logic        eRdValid;
    logic [31:0] eRdata;
    logic        eRdLast;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic cv, input logic cw, input logic [4:0] base, input logic [4:0] len,
    input logic wv, input logic [31:0] wd, input logic rr,
    input logic eBusy, input logic eDone, input logic eWdReady, input logic eWrEn,
    input logic [4:0] ePtr, input logic eRdValid, input logic [31:0] eRdata, input logic eRdLast);
    vec_t v;
    v.cv = cv; v.cw = cw; v.base = base; v.len = len;
    v.wv = wv; v.wd = wd; v.rr = rr;
    v.eBusy = eBusy; v.eDone = eDone; v.eWdReady = eWdReady; v.eWrEn = eWrEn;
    v.ePtr = ePtr; v.eRdValid = eRdValid; v.eRdata = eRdata; v.eRdLast = eRdLast;
    return v;
  endfunction

  localparam logic [31:0] A0 = 32'hA000_0000;
  localparam logic [31:0] A1 = 32'hA111_1111;
  localparam logic [31:0] A2 = 32'hA222_2222;
  localparam logic [31:0] A3 = 32'hA333_3333;
  localparam logic [31:0] B0 = 32'hB000_0008;
  localparam logic [31:0] B1 = 32'hB000_0009;
  localparam logic [31:0] B2 = 32'hB000_000A;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  // scoreboard
  logic [31:0] exp_q[$];

  initial begin
    int beats;
    int doneSeen;
    int badCount;
    int cyc;
    logic [31:0] expData;

    // WRITE base 30 len 3 with gaps before beats 1 and 3
    tbl.push_back(mk(1,1,30,3, 0,0,0,  0,0,0,0,30-30, 0,0,0));
    tbl.push_back(mk(0,0,0,0,  1,A0,0, 1,0,1,1,30,   0,0,0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,  1,0,1,0,31,   0,0,0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,  1,0,1,0,31,   0,0,0));
    tbl.push_back(mk(0,0,0,0,  1,A1,0, 1,0,1,1,31,   0,0,0));
    tbl.push_back(mk(0,0,0,0,  1,A2,0, 1,0,1,1,0,    0,0,0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,  1,0,1,0,1,    0,0,0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,  1,0,1,0,1,    0,0,0));
    tbl.push_back(mk(0,0,0,0,  1,A3,0, 1,0,1,1,1,    0,0,0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,  0,1,0,0,2,    0,0,0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,  0,0,0,0,2,    0,0,0));
    // READ base 4 len 2, RdReady held high
    tbl.push_back(mk(1,0,4,2,  0,0,1,  0,0,0,0,2,    0,0,0));
    tbl.push_back(mk(0,0,0,0,  0,0,1,  1,0,0,0,4,    0,0,0));
    tbl.push_back(mk(0,0,0,0,  0,0,1,  1,0,0,0,5,    1,32'h11,0));
    tbl.push_back(mk(0,0,0,0,  0,0,1,  1,0,0,0,6,    1,32'h22,0));
    tbl.push_back(mk(0,0,0,0,  0,0,1,  1,0,0,0,7,    1,32'h33,1));
    tbl.push_back(mk(0,0,0,0,  0,0,1,  0,1,0,0,7,    0,0,0));
    tbl.push_back(mk(0,0,0,0,  0,0,1,  0,0,0,0,7,    0,0,0));
    // READ base 0 len 1, beat 0 back-pressured for 3 cycles
    tbl.push_back(mk(1,0,0,1,  0,0,0,  0,0,0,0,7,    0,0,0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,  1,0,0,0,0,    0,0,0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,  1,0,0,0,1,    1,A2,0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,  1,0,0,0,1,    1,A2,0));
    tbl.push_back(mk(0,0,0,0,  0,0,0,  1,0,0,0,1,    1,A2,0));
    tbl.push_back(mk(0,0,0,0,  0,0,1,  1,0,0,0,1,    1,A2,0));
    tbl.push_back(mk(0,0,0,0,  0,0,1,  1,0,0,0,2,    1,A3,1));
    tbl.push_back(mk(0,0,0,0,  0,0,1,  0,1,0,0,2,    0,0,0));
    // back-to-back WRITE 12 then READ 12 issued in the Done cycle
    tbl.push_back(mk(1,1,12,0, 1,DB,1, 0,0,0,0,2,    0,0,0));
    tbl.push_back(mk(0,0,0,0,  1,DB,1, 1,0,1,1,12,   0,0,0));
    tbl.push_back(mk(1,0,12,0, 0,0,1,  0,1,0,0,13,   0,0,0));
    tbl.push_back(mk(0,0,0,0,  0,0,1,  1,0,0,0,12,   0,0,0));
    tbl.push_back(mk(0,0,0,0,  0,0,1,  1,0,0,0,13,   1,DB,1));
    tbl.push_back(mk(0,0,0,0,  0,0,1,  0,1,0,0,13,   0,0,0));

    for (int k = 0; k < 32; k++) wrCount[k] = 0;

    // preload register file while the DUT is held in reset
    preWe = 1'b1;
    for (int k = 0; k < 32; k++) begin
      preAddr = k[4:0];
      preData = (k == 4) ? 32'h11 : (k == 5) ? 32'h22 : (k == 6) ? 32'h33 : 32'hC000_0000 + k;
      step();
    end
    preWe = 1'b0;

    @(negedge Clk);
    chk("reset CmdReady", {31'd0, CmdReady}, 32'd1);
    chk("reset Busy", {31'd0, Busy}, 32'd0);
    chk("reset RdValid", {31'd0, RdValid}, 32'd0);
    chk("reset Rdata", Rdata, 32'd0);
    chk("reset RdLast", {31'd0, RdLast}, 32'd0);
    chk("reset Done", {31'd0, Done}, 32'd0);
    chk("reset RfWrEn", {31'd0, RfWrEn}, 32'd0);
    chk("reset WdReady", {31'd0, WdReady}, 32'd0);
    chk("reset RfArd", {27'd0, RfArd}, 32'd0);

    // reset mid-WRITE: 4-beat burst to base 8, reset after beat 2
    step();
    Rst = 1'b0;
    CmdValid = 1'b1; CmdWrite = 1'b1; CmdBase = 5'd8; CmdLen = 5'd3;
    step();
    CmdValid = 1'b0;
    WdValid = 1'b1; Wdata = B0;
    step();
    Wdata = B1;
    step();
    Wdata = B2;
    Rst = 1'b1;
    #1;
    chk("midrst RfWrEn", {31'd0, RfWrEn}, 32'd0);
    chk("midrst Busy", {31'd0, Busy}, 32'd0);
    step();
    Rst = 1'b0;
    WdValid = 1'b0; Wdata = '0;
    @(negedge Clk);
    chk("midrst CmdReady", {31'd0, CmdReady}, 32'd1);
    chk("midrst Ptr", {27'd0, RfArd}, 32'd0);
    chk("midrst R8", rf[8], B0);
    chk("midrst R9", rf[9], B1);
    chk("midrst R10", rf[10], 32'hC000_000A);
    chk("midrst R11", rf[11], 32'hC000_000B);
    step();

    // per-cycle vector table
    for (int i = 0; i < tbl.size(); i++) begin
      CmdValid = tbl[i].cv; CmdWrite = tbl[i].cw; CmdBase = tbl[i].base; CmdLen = tbl[i].len;
      WdValid = tbl[i].wv; Wdata = tbl[i].wd; RdReady = tbl[i].rr;
      @(negedge Clk);
      chk($sformatf("v%0d CmdReady", i), {31'd0, CmdReady}, {31'd0, !tbl[i].eBusy});
      chk($sformatf("v%0d Busy", i), {31'd0, Busy}, {31'd0, tbl[i].eBusy});
      chk($sformatf("v%0d Done", i), {31'd0, Done}, {31'd0, tbl[i].eDone});
      chk($sformatf("v%0d WdReady", i), {31'd0, WdReady}, {31'd0, tbl[i].eWdReady});
      chk($sformatf("v%0d RfWrEn", i), {31'd0, RfWrEn}, {31'd0, tbl[i].eWrEn});
      chk($sformatf("v%0d RfArd", i), {27'd0, RfArd}, {27'd0, tbl[i].ePtr});
      chk($sformatf("v%0d RfAwr", i), {27'd0, RfAwr}, {27'd0, tbl[i].ePtr});
      chk($sformatf("v%0d RdValid", i), {31'd0, RdValid}, {31'd0, tbl[i].eRdValid});
      chk($sformatf("v%0d RdLast", i), {31'd0, RdLast}, {31'd0, tbl[i].eRdLast});
      if (tbl[i].eRdValid) chk($sformatf("v%0d Rdata", i), Rdata, tbl[i].eRdata);
      if (tbl[i].eWrEn) chk($sformatf("v%0d RfDin", i), RfDin, tbl[i].wd);
      step();
    end
    CmdValid = 1'b0; WdValid = 1'b0; RdReady = 1'b0;

    chk("wgap R30", rf[30], A0);
    chk("wgap R31", rf[31], A1);
    chk("wgap R0", rf[0], A2);
    chk("wgap R1", rf[1], A3);
    chk("wgap R2 untouched", rf[2], 32'hC000_0002);
    chk("b2b R12", rf[12], DB);

    // full sweep: 32-beat WRITE from base 17, data = beat index, then 32-beat READ
    wrClr = 1'b1;
    step();
    wrClr = 1'b0;
    CmdValid = 1'b1; CmdWrite = 1'b1; CmdBase = 5'd17; CmdLen = 5'd31;
    step();
    CmdValid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      WdValid = 1'b1; Wdata = i;
      step();
    end
    WdValid = 1'b0; Wdata = '0;
    chk("sweep write Done", {31'd0, Done}, 32'd1);
    chk("sweep write Busy", {31'd0, Busy}, 32'd0);
    badCount = 0;
    for (int k = 0; k < 32; k++) if (wrCount[k] != 1) badCount++;
    chk("sweep regs not written once", badCount, 32'd0);

    for (int i = 0; i < 32; i++) exp_q.push_back(i);
    CmdValid = 1'b1; CmdWrite = 1'b0; CmdBase = 5'd17; CmdLen = 5'd31; RdReady = 1'b1;
    step();
    CmdValid = 1'b0;
    beats = 0; doneSeen = 0; cyc = 0;
    while (doneSeen == 0 && cyc < 100) begin
      @(negedge Clk);
      if (Done) doneSeen++;
      if (RdValid && RdReady) begin
        if (exp_q.size() == 0) begin
          chk("sweep extra beat", {31'd0, RdValid}, 32'd0);
        end else begin
          expData = exp_q.pop_front();
          chk($sformatf("sweep Rdata %0d", beats), Rdata, expData);
          chk($sformatf("sweep RdLast %0d", beats), {31'd0, RdLast}, {31'd0, exp_q.size() == 0});
        end
        beats++;
      end
      cyc++;
    end
    chk("sweep read timeout", {31'd0, doneSeen == 0}, 32'd0);
    chk("sweep beat count", beats, 32'd32);
    chk("sweep queue empty", exp_q.size(), 32'd0);
    @(negedge Clk);
    chk("sweep Done single", {31'd0, Done}, 32'd0);
    RdReady = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
